// File: rtl/dout_packer.sv
// Selects one 2-bit result stream, packs NSYM symbols per word into a
// double-buffered valid/ready output, and counts carry activity.
module dout_packer #(
  parameter int unsigned NSYM  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [1:0]          do1,
  input  logic [1:0]          do2,
  input  logic [1:0]          do3,
  input  logic                co1,
  input  logic                co2,
  input  logic [1:0]          src_sel,
  input  logic                in_en,
  input  logic                clear,
  input  logic                out_ready,
  output logic [2*NSYM-1:0]   out_data,
  output logic                out_valid,
  output logic                overflow,
  output logic [CNT_W-1:0]    co_cnt
);

  localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;

  typedef enum logic {EMPTY, FULL} buf_state_e;

  buf_state_e        state_q;
  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic [2*NSYM-1:0] fill_q, fill_d;
  logic [2*NSYM-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              ovf_q;

  logic [1:0]        sym;
  logic [2*NSYM-1:0] word;
  logic              sample;
  logic              complete;
  logic              xfer;

  always_comb begin
    sym = '0;
    case (src_sel)
      2'd0:    sym = do1;
      2'd1:    sym = do2;
      2'd2:    sym = do3;
      default: sym = '0;
    endcase
  end

  // clear suppresses a same-cycle sample
  assign sample   = in_en & ~clear;
  assign complete = sample && (idx_q == IDX_W'(NSYM - 1));
  assign xfer     = (state_q == FULL) && out_ready;

  always_comb begin
    word = fill_q;
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (idx_q == IDX_W'(i)) word[2*i +: 2] = sym;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (clear) begin
      idx_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (sample) begin
      if (complete) begin
        idx_d  = '0;
        fill_d = '0;
      end else begin
        idx_d  = idx_q + 1'b1;
        fill_d = word;
      end
      if ((co1 | co2) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      if (clear) ovf_q <= 1'b0;
      case (state_q)
        EMPTY: begin
          if (complete) begin
            data_q  <= word;
            state_q <= FULL;
          end
        end
        FULL: begin
          // a word completing while the old one is accepted replaces it
          if (xfer && complete) begin
            data_q <= word;
          end else if (xfer) begin
            state_q <= EMPTY;
          end else if (complete) begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == FULL);
  assign overflow  = ovf_q;
  assign co_cnt    = cnt_q;

endmodule

// File: tb/tb_dout_packer.sv
// Randomized and directed checks of dout_packer against a queue-based model.
module tb_dout_packer;

  localparam int unsigned NSYM  = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [1:0]       do1, do2, do3;
  logic             co1, co2;
  logic [1:0]       src_sel;
  logic             in_en, clear, out_ready;
  logic [2*NSYM-1:0] out_data;
  logic             out_valid, overflow;
  logic [CNT_W-1:0] co_cnt;

  dout_packer #(.NSYM(NSYM), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .do1(do1), .do2(do2), .do3(do3),
    .co1(co1), .co2(co2), .src_sel(src_sel), .in_en(in_en), .clear(clear),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .overflow(overflow), .co_cnt(co_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int unsigned syms[$];
  bit          m_valid;
  int unsigned m_data;
  bit          m_ovf;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned pick();
    case (src_sel)
      2'd0:    return int'(do1);
      2'd1:    return int'(do2);
      2'd2:    return int'(do3);
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    bit          done;
    bit          xfer;
    int unsigned w;
    done = 0;
    w    = 0;
    if (!n_rst) begin
      syms.delete();
      m_valid = 0; m_data = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    xfer = m_valid && out_ready;
    if (clear) begin
      syms.delete();
      m_cnt = 0;
      m_ovf = 0;
    end else if (in_en) begin
      syms.push_back(pick());
      if ((co1 || co2) && m_cnt < (2**CNT_W - 1)) m_cnt++;
      if (syms.size() == NSYM) begin
        foreach (syms[i]) w += syms[i] * (4 ** i);
        syms.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || xfer) begin
        m_data  = w;
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk("data", 32'(out_data), m_data);
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("cnt", 32'(co_cnt), m_cnt);
  endtask

  task automatic idle();
    in_en = 0; clear = 0; co1 = 0; co2 = 0; n_rst = 1;
  endtask

  initial begin
    n_rst = 0; do1 = 0; do2 = 0; do3 = 0; co1 = 0; co2 = 0;
    src_sel = 0; in_en = 0; clear = 0; out_ready = 0;
    tick(); tick();
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);

    // 1: basic packing order
    idle(); src_sel = 0; in_en = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      do1 = 2'((i + 1) % 4);
      tick();
      if (i == 2) chk("t1_notyet", 32'(out_valid), 32'h0);
    end
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'h39);

    // 2: reset mid-word discards the partial word
    idle(); out_ready = 1; tick(); out_ready = 0;
    src_sel = 2; do3 = 1; in_en = 1; tick(); tick();
    in_en = 0; n_rst = 0; tick();
    chk("t2_rst_valid", 32'(out_valid), 32'h0);
    n_rst = 1; in_en = 1; do3 = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) chk("t2_nostale", 32'(out_valid), 32'h0);
    end
    chk("t2_data", 32'(out_data), 32'hFF);

    // 3: overflow when second word cannot be stored
    idle(); n_rst = 0; tick(); idle();
    src_sel = 1; do2 = 1; in_en = 1; out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) chk("t3_noovf_yet", 32'(overflow), 32'h0);
    end
    chk("t3_ovf", 32'(overflow), 32'h1);
    chk("t3_data", 32'(out_data), 32'h55);

    // 4: transfer and completion in the same cycle
    idle(); clear = 1; tick(); clear = 0;
    src_sel = 0; do1 = 2; in_en = 1;
    tick(); tick(); tick();
    out_ready = 1; tick();
    chk("t4_valid", 32'(out_valid), 32'h1);
    chk("t4_data", 32'(out_data), 32'hAA);
    chk("t4_ovf", 32'(overflow), 32'h0);

    // 5: saturating carry counter
    idle(); out_ready = 1; co1 = 1; in_en = 1;
    for (int i = 0; i < 300; i++) tick();
    chk("t5_sat", 32'(co_cnt), 32'd255);
    tick();
    chk("t5_hold", 32'(co_cnt), 32'd255);
    idle(); clear = 1; tick();
    chk("t5_clr", 32'(co_cnt), 32'd0);

    // 6: constant source, clear mid-word keeps output buffer
    idle(); out_ready = 1; tick(); out_ready = 0;
    src_sel = 3; in_en = 1;
    for (int i = 0; i < 4; i++) begin
      do1 = 2'($urandom); do2 = 2'($urandom); do3 = 2'($urandom);
      tick();
    end
    chk("t6_data", 32'(out_data), 32'h00);
    chk("t6_valid", 32'(out_valid), 32'h1);
    src_sel = 0; do1 = 3; tick(); tick();
    in_en = 0; clear = 1; tick(); clear = 0;
    chk("t6_keep_valid", 32'(out_valid), 32'h1);
    chk("t6_keep_data", 32'(out_data), 32'h00);
    out_ready = 1; tick(); out_ready = 0;
    in_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) chk("t6_restart", 32'(out_valid), 32'h0);
    end
    chk("t6_word", 32'(out_data), 32'hFF);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      n_rst     = ($urandom_range(0, 79) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      in_en     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      src_sel   = 2'($urandom);
      do1 = 2'($urandom); do2 = 2'($urandom); do3 = 2'($urandom);
      co1 = ($urandom_range(0, 3) == 0);
      co2 = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
